// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave cook timer.
// Contents: FSM state enum, BCD digit type, BCD digit limits.
// No ports; imported by microwave_timer and bcd_digit_dec.
package microwave_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // time zero, never run
        SET  = 2'd1,  // time nonzero, not counting
        RUN  = 2'd2,  // counting down
        DONE = 2'd3   // expired
    } timer_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX_SEC_TENS = 4'd5;
    localparam bcd_t BCD_MAX_DIGIT    = 4'd9;

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of a borrow-chain decrementer (pure combinational, no latency).
// Ports: digit_i/borrow_i in; digit_o/borrow_o out; wrap_i is the value loaded on borrow from 0.
// Chained ones -> tens -> minutes to decrement M:SS by one second.
module bcd_digit_dec
    import microwave_pkg::*;
(
    input  bcd_t digit_i,
    input  logic borrow_i,
    input  bcd_t wrap_i,
    output bcd_t digit_o,
    output logic borrow_o
);

    always_comb begin
        digit_o  = digit_i;
        borrow_o = 1'b0;
        if (borrow_i) begin
            if (digit_i == 4'd0) begin
                digit_o  = wrap_i;
                borrow_o = 1'b1;
            end else begin
                digit_o = digit_i - 4'd1;
            end
        end
    end

endmodule

// File: rtl/microwave_timer.sv
// Cook-time countdown timer: keypad BCD entry (M:SS), 1 Hz countdown while magnetron runs.
// Ports: clk/resetn (sync active-low), clearn, magnetron_on, key_valid/key_digit in;
//        timer_done, done_pulse, min_ones/sec_tens/sec_ones, running, beep out.
// Optional macro MICROWAVE_TIMER_BEEP_EN adds a timed beeper; otherwise beep is tied 0.
module microwave_timer
    import microwave_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100,
    parameter int BEEP_SECS     = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clearn,
    input  logic       magnetron_on,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    output logic       timer_done,
    output logic       done_pulse,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       beep
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    timer_state_t  state_q, state_d;
    bcd_t          min_q, min_d, tens_q, tens_d, ones_q, ones_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          timer_done_q, timer_done_d;
    logic          done_pulse_q, done_pulse_d;
    logic          beep_start, beep_stop;

    // Borrow chain: ones always borrows; tens wraps to 5, minutes to 9.
    bcd_t dec_ones, dec_tens, dec_min;
    logic brw_ones, brw_tens, brw_min;

    bcd_digit_dec u_dec_ones (.digit_i(ones_q), .borrow_i(1'b1),     .wrap_i(BCD_MAX_DIGIT),
                              .digit_o(dec_ones), .borrow_o(brw_ones));
    bcd_digit_dec u_dec_tens (.digit_i(tens_q), .borrow_i(brw_ones), .wrap_i(BCD_MAX_SEC_TENS),
                              .digit_o(dec_tens), .borrow_o(brw_tens));
    bcd_digit_dec u_dec_min  (.digit_i(min_q),  .borrow_i(brw_tens), .wrap_i(BCD_MAX_DIGIT),
                              .digit_o(dec_min),  .borrow_o(brw_min));

    logic time_zero, dec_zero, key_ok, count_en;
    bcd_t base_tens, base_ones;

    assign time_zero = (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);
    assign dec_zero  = (dec_min == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);
    assign key_ok    = key_valid && !magnetron_on && (state_q != RUN) &&
                       (key_digit <= BCD_MAX_DIGIT);
    // Counting starts on the same edge RUN is entered, so a full second is
    // exactly TICKS_PER_SEC cycles of magnetron_on; a paused prescaler resumes
    // where it stopped. Zero time never counts (the latch is held reset).
    assign count_en  = magnetron_on && !time_zero;
    // A key in DONE starts a fresh entry from 0:00.
    assign base_tens = (state_q == DONE) ? 4'd0 : tens_q;
    assign base_ones = (state_q == DONE) ? 4'd0 : ones_q;

    always_comb begin
        state_d      = state_q;
        min_d        = min_q;
        tens_d       = tens_q;
        ones_d       = ones_q;
        presc_d      = presc_q;
        done_pulse_d = 1'b0;
        beep_start   = 1'b0;
        beep_stop    = 1'b0;
        if (!clearn) begin
            state_d   = IDLE;
            min_d     = 4'd0;
            tens_d    = 4'd0;
            ones_d    = 4'd0;
            presc_d   = '0;
            beep_stop = 1'b1;
        end else if (count_en) begin
            state_d = RUN;
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                min_d   = dec_min;
                tens_d  = dec_tens;
                ones_d  = dec_ones;
                if (dec_zero) begin
                    state_d      = DONE;
                    done_pulse_d = 1'b1;
                    beep_start   = 1'b1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end else if (state_q == RUN) begin
            // Door opened / stop: pause, prescaler held.
            state_d = SET;
        end else if (key_ok) begin
            min_d     = base_tens;
            tens_d    = base_ones;
            ones_d    = key_digit;
            state_d   = ((base_tens | base_ones | key_digit) != 4'd0) ? SET : IDLE;
            beep_stop = 1'b1;
        end
    end

    assign timer_done_d = (min_d == 4'd0) && (tens_d == 4'd0) && (ones_d == 4'd0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            min_q        <= 4'd0;
            tens_q       <= 4'd0;
            ones_q       <= 4'd0;
            presc_q      <= '0;
            timer_done_q <= 1'b1;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            min_q        <= min_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            presc_q      <= presc_d;
            timer_done_q <= timer_done_d;
            done_pulse_q <= done_pulse_d;
        end
    end

`ifdef MICROWAVE_TIMER_BEEP_EN
    localparam int BEEP_CYC = BEEP_SECS * TICKS_PER_SEC;
    localparam int BW       = $clog2(BEEP_CYC + 1);

    logic [BW-1:0] beep_cnt_q, beep_cnt_d;

    always_comb begin
        beep_cnt_d = beep_cnt_q;
        if (beep_stop) begin
            beep_cnt_d = '0;
        end else if (beep_start) begin
            beep_cnt_d = BW'(BEEP_CYC);
        end else if (beep_cnt_q != '0) begin
            beep_cnt_d = beep_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            beep_cnt_q <= '0;
        end else begin
            beep_cnt_q <= beep_cnt_d;
        end
    end

    assign beep = (beep_cnt_q != '0);
`else
    logic unused_beep;
    assign unused_beep = beep_start ^ beep_stop ^ (BEEP_SECS != 0);
    assign beep        = 1'b0;
`endif

    assign timer_done = timer_done_q;
    assign done_pulse = done_pulse_q;
    assign min_ones   = min_q;
    assign sec_tens   = tens_q;
    assign sec_ones   = ones_q;
    assign running    = (state_q == RUN);

endmodule

// File: tb/tb_microwave_timer.sv
module tb_microwave_timer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       clearn = 1'b1;
    logic       magnetron_on = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       timer_done, done_pulse, running, beep;
    logic [3:0] min_ones, sec_tens, sec_ones;

    int checks = 0;
    int failures = 0;

    microwave_timer #(.TICKS_PER_SEC(4), .BEEP_SECS(2)) dut (
        .clk(clk), .resetn(resetn), .clearn(clearn), .magnetron_on(magnetron_on),
        .key_valid(key_valid), .key_digit(key_digit), .timer_done(timer_done),
        .done_pulse(done_pulse), .min_ones(min_ones), .sec_tens(sec_tens),
        .sec_ones(sec_ones), .running(running), .beep(beep)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int tm();
        return {20'd0, min_ones, sec_tens, sec_ones};
    endfunction

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        step(1);
        key_valid = 1'b0;
    endtask

    task automatic clear();
        clearn = 1'b0;
        step(1);
        clearn = 1'b1;
    endtask

    int nbeep;
    int expected_beep_cycles;

    initial begin
`ifdef MICROWAVE_TIMER_BEEP_EN
        expected_beep_cycles = 8;
`else
        expected_beep_cycles = 0;
`endif
        // Reset state
        step(2);
        check("rst_time", tm(), 'h000);
        check("rst_timer_done", int'(timer_done), 1);
        check("rst_done_pulse", int'(done_pulse), 0);
        check("rst_running", int'(running), 0);
        check("rst_beep", int'(beep), 0);
        resetn = 1'b1;

        // Key entry
        key(4'd1); key(4'd3); key(4'd0);
        check("key_130", tm(), 'h130);
        check("key_130_done", int'(timer_done), 0);
        check("key_130_run", int'(running), 0);
        key(4'd5);
        check("key_shift_305", tm(), 'h305);
        key(4'd12);
        check("key_invalid", tm(), 'h305);

        // 1:00 countdown to expiry
        clear();
        check("clr_time", tm(), 'h000);
        check("clr_timer_done", int'(timer_done), 1);
        key(4'd1); key(4'd0); key(4'd0);
        check("load_100", tm(), 'h100);
        magnetron_on = 1'b1;
        step(3);
        check("run_3cyc", tm(), 'h100);
        check("run_running", int'(running), 1);
        step(1);
        check("borrow_059", tm(), 'h059);
        step(232);
        check("run_001", tm(), 'h001);
        step(3);
        check("pre_exp_pulse", int'(done_pulse), 0);
        step(1);
        check("exp_time", tm(), 'h000);
        check("exp_pulse", int'(done_pulse), 1);
        check("exp_timer_done", int'(timer_done), 1);
        check("exp_running", int'(running), 0);
        nbeep = int'(beep);
        magnetron_on = 1'b0;
        step(1);
        check("pulse_one_cycle", int'(done_pulse), 0);
        nbeep += int'(beep);
        for (int i = 0; i < 14; i++) begin
            step(1);
            nbeep += int'(beep);
        end
        check("beep_cycles", nbeep, expected_beep_cycles);

        // Pause / resume with frozen prescaler
        key(4'd0); key(4'd5);
        check("load_005", tm(), 'h005);
        magnetron_on = 1'b1;
        step(6);
        check("run6_time", tm(), 'h004);
        magnetron_on = 1'b0;
        step(10);
        check("pause_time", tm(), 'h004);
        check("pause_running", int'(running), 0);
        check("pause_timer_done", int'(timer_done), 0);
        magnetron_on = 1'b1;
        step(1);
        check("resume1", tm(), 'h004);
        check("resume_running", int'(running), 1);
        step(1);
        check("resume2_dec", tm(), 'h003);

        // Clear mid-RUN
        magnetron_on = 1'b0;
        step(1);
        clear();
        key(4'd1); key(4'd0);
        magnetron_on = 1'b1;
        step(2);
        check("pre_clr_time", tm(), 'h010);
        clearn = 1'b0;
        step(1);
        clearn = 1'b1;
        check("midclr_time", tm(), 'h000);
        check("midclr_timer_done", int'(timer_done), 1);
        check("midclr_running", int'(running), 0);
        check("midclr_pulse", int'(done_pulse), 0);
        key(4'd4);
        check("key_while_on", tm(), 'h000);
        check("idle_no_run", int'(running), 0);

        // Key during beep ends it
        magnetron_on = 1'b0;
        key(4'd0); key(4'd1);
        magnetron_on = 1'b1;
        step(4);
        check("exp2_pulse", int'(done_pulse), 1);
        magnetron_on = 1'b0;
        step(2);
        check("beep_cyc3", int'(beep), expected_beep_cycles != 0 ? 1 : 0);
        key(4'd7);
        check("beep_key_off", int'(beep), 0);
        check("done_key_time", tm(), 'h007);
        check("done_key_timer_done", int'(timer_done), 0);

        // sec_tens above 5 counts as plain seconds
        clear();
        key(4'd9); key(4'd0);
        magnetron_on = 1'b1;
        step(4);
        check("dec_090", tm(), 'h089);

        // Reset mid-RUN
        magnetron_on = 1'b0;
        step(1);
        clear();
        key(4'd4); key(4'd2);
        magnetron_on = 1'b1;
        step(3);
        check("pre_rst_time", tm(), 'h042);
        resetn = 1'b0;
        step(1);
        check("rst2_time", tm(), 'h000);
        check("rst2_timer_done", int'(timer_done), 1);
        check("rst2_running", int'(running), 0);
        check("rst2_pulse", int'(done_pulse), 0);
        check("rst2_beep", int'(beep), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/microwave_timer.md
Name: microwave_timer

Overview:
- Cook-time countdown timer for the microwave controller; closes the loop with the magnetron control latch.
- Accepts keypad digits into a 3-digit BCD time (M:SS) and counts it down at 1 Hz while the magnetron runs.
- Drives the `timer_done` input of the magnetron control latch, so the latch cannot start on zero time and is reset when time expires.
- Also feeds the display and beeper.

Parameters:
- TICKS_PER_SEC, 100, clk cycles per second of countdown (prescaler terminal count); must be >= 2.
- BEEP_SECS, 3, beep duration in seconds; used only with MICROWAVE_TIMER_BEEP_EN.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- resetn  input  1  synchronous active-low reset
- clearn  input  1  active-low clear, same signal as the magnetron controller's clearn
- magnetron_on  input  1  Q of the magnetron control latch; countdown enabled while high
- key_valid  input  1  one-cycle strobe: key_digit is valid
- key_digit  input  4  BCD digit 0..9 from keypad
- timer_done  output  1  high whenever remaining time is 0:00
- done_pulse  output  1  one-cycle pulse when countdown reaches 0:00
- min_ones  output  4  BCD minutes
- sec_tens  output  4  BCD tens of seconds
- sec_ones  output  4  BCD ones of seconds
- running  output  1  high in RUN state
- beep  output  1  beeper drive (only with MICROWAVE_TIMER_BEEP_EN; tied 0 otherwise)

Behaviour:
- Reset (resetn=0 at clk edge):
  - State IDLE.
  - All digits 0, prescaler 0.
  - timer_done=1, done_pulse=0, running=0, beep=0.
- FSM states: IDLE (time zero, never run), SET (time nonzero, not counting), RUN (counting), DONE (expired).
- Priority per cycle, highest first: resetn, then clearn, then countdown tick, then key entry.
- clearn=0: digits to 0, prescaler to 0, state IDLE, beep off. Applies in any state, including mid-RUN; timer_done rises the next cycle, which stops the magnetron.
- Key entry:
  - Accepted only when key_valid=1, magnetron_on=0, state is not RUN, and key_digit<=9. Otherwise the key is ignored silently.
  - Shift-left entry: min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=key_digit. The old min_ones is discarded.
  - sec_tens may hold 6..9 (e.g. 0:90 is legal and counts down as 90 seconds).
  - After a key, state is SET if the result is nonzero, else IDLE. A key in DONE starts a new entry from 0:00 (digits cleared before the shift) and stops the beep.
- IDLE/SET/DONE -> RUN: when magnetron_on=1 and time is nonzero. With zero time timer_done=1 holds the latch reset, so RUN is not entered.
- RUN:
  - While magnetron_on=1 the prescaler increments each cycle; at TICKS_PER_SEC-1 it wraps to 0 and the time decrements by one second.
  - Decrement with BCD borrow: sec_ones 0->9 borrows from sec_tens; sec_tens 0->5 borrows from min_ones. Example: 1:00 -> 0:59.
  - magnetron_on=0 in RUN (door opened or stop): go to SET and hold the prescaler value (pause). Resume from the same prescaler value on the next RUN.
- Expiry: when a decrement yields 0:00, state DONE and prescaler 0 in the same edge.
  - done_pulse=1 for exactly that one cycle.
  - timer_done=1 from that cycle onward.
- timer_done is registered and equals (time==0:00); there is no combinational path from inputs.
- running is 1 only in RUN.
- Decrement never occurs from 0:00; there is no wrap to 9:59.

Optional Feature:
- MICROWAVE_TIMER_BEEP_EN defined:
  - beep rises with done_pulse and stays high for BEEP_SECS*TICKS_PER_SEC cycles, timed by a dedicated beep counter.
  - clearn=0 or an accepted key ends the beep early.
  - Reset clears the beep counter.
- MICROWAVE_TIMER_BEEP_EN undefined: no beep counter; beep tied to 0.

Decomposition:
- Shared package microwave_pkg:
  - state enum timer_state_t {IDLE, SET, RUN, DONE}
  - bcd_t (4-bit) digit type
  - constant BCD_MAX_SEC_TENS=5
- One natural sub-module: bcd_digit_dec (input digit, borrow_in, wrap value; output digit, borrow_out), instantiated three times to form the borrow chain.

Test Plan (TICKS_PER_SEC=4, BEEP_SECS=2):
- Reset then keys 1,3,0 -> digits 1:30, state SET, timer_done=0. A fourth key 5 -> 3:05. key_digit=12 -> ignored, still 3:05.
- Load 1:00, magnetron_on=1 for 4 cycles -> 0:59. After 60 s (240 cycles) total -> 0:00, done_pulse for exactly 1 cycle, timer_done=1, running=0.
- Load 0:05, run 6 cycles (1 s + 2 ticks), drop magnetron_on for 10 cycles -> state SET, time 0:04, prescaler frozen at 2. Re-raise -> next decrement after 2 cycles.
- Load 0:10, run, assert clearn=0 mid-second -> next cycle 0:00, IDLE, timer_done=1, no done_pulse. Keys while magnetron_on=1 -> ignored.
- With MICROWAVE_TIMER_BEEP_EN: expiry -> beep high 8 cycles. Repeat and press key 7 at cycle 3 -> beep falls, time 0:07, state SET.
- resetn=0 mid-RUN at 0:42 -> next edge 0:00, IDLE, all outputs at reset values.
